// File: rtl/mb_crc_serializer.sv
// mb_crc_serializer: parallel-load serializer for a serial-link transmitter.
// A data word is shifted out MSB first and a CRC is computed over it bit by
// bit. The CRC remainder is then shifted out MSB first. Cout tells the link
// controller when the last bit of the current phase is on Sout.
module mb_crc_serializer #(
  parameter int              DATA_W   = 8,
  parameter int              CRC_W    = 4,
  parameter logic [CRC_W-1:0] POLY     = 4'b0011,
  parameter logic [CRC_W-1:0] CRC_INIT = 4'b0000
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              Load,
  input  logic              Select,
  input  logic              ShiftEn,
  input  logic [DATA_W-1:0] Din,
  output logic              Sout,
  output logic              Cout,
  output logic [CRC_W-1:0]  CRC
);

  // The counter has to hold DATA_W-1. CRC_W-1 always fits because CRC_W <= DATA_W.
  localparam int NW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [NW-1:0] LAST_D = NW'(DATA_W - 1);
  localparam logic [NW-1:0] LAST_C = NW'(CRC_W - 1);

  logic [DATA_W-1:0] d;
  logic [CRC_W-1:0]  c;
  logic [NW-1:0]     n;

  logic [NW-1:0]     last;
  logic              term;
  logic              fb;

  // The terminal count follows Select at once. Switching phase part-way
  // through can therefore raise Cout on a counter that was not cleared.
  assign last = Select ? LAST_C : LAST_D;
  assign term = (n >= last);
  assign fb   = d[DATA_W-1] ^ c[CRC_W-1];

  // Combinational outputs. Sout is the bit that the next enabled edge shifts out.
  assign Sout = Select ? c[CRC_W-1] : d[DATA_W-1];
  assign Cout = term;
  assign CRC  = c;

  // Register update. Priority is CLR, then Load, then ShiftEn, otherwise hold.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      d <= '0;
      c <= CRC_INIT;
      n <= '0;
    end else if (Load) begin
      d <= Din;
      c <= CRC_INIT;
      n <= '0;
    end else if (ShiftEn) begin
      if (!Select) begin
        d <= {d[DATA_W-2:0], 1'b0};
        c <= {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      end else begin
        c <= {c[CRC_W-2:0], 1'b0};
      end
      // The counter wraps on the terminal shift, so the CRC phase begins at 0.
      n <= term ? '0 : n + 1'b1;
    end
  end

endmodule

// File: tb/tb_mb_crc_serializer.sv
// Testbench for mb_crc_serializer. A cycle-level reference model pushes the
// expected outputs of each cycle into a scoreboard queue. Those entries are
// popped and compared at the falling edge. Complete frames are also checked
// against constant streams and against a long-division CRC.
module tb_mb_crc_serializer;

  logic       clk = 1'b0;
  logic       clr, load, sel, en;
  logic [7:0] din;
  logic       sout, cout;
  logic [3:0] crc;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       sout;
    logic       cout;
    logic [3:0] crc;
  } exp_t;
  exp_t sb_q[$];

  // Reference state
  logic [7:0] md;
  logic [3:0] mc;
  int         mn;

  // Bits captured from the DUT on enabled shifts
  logic [31:0] stream;

  mb_crc_serializer #(.DATA_W(8), .CRC_W(4), .POLY(4'b0011), .CRC_INIT(4'b0000)) dut (
    .CLK(clk), .CLR(clr), .Load(load), .Select(sel), .ShiftEn(en),
    .Din(din), .Sout(sout), .Cout(cout), .CRC(crc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Remainder of din*x^4 mod (x^4+x+1), computed by long division
  function automatic logic [3:0] crc_div(input logic [7:0] v);
    logic [11:0] r;
    r = {v, 4'b0000};
    for (int i = 11; i >= 4; i--)
      if (r[i]) r = r ^ (12'b10011 << (i - 4));
    return r[3:0];
  endfunction

  // Runs one clock. Drives inputs, pushes the expected outputs and compares them at
  // the falling edge. The reference model then advances on the rising edge.
  task automatic cyc(input logic c_, input logic l_, input logic s_, input logic e_,
                     input logic [7:0] d_);
    exp_t e, g;
    int   last;
    clr = c_; load = l_; sel = s_; en = e_; din = d_;
    last = s_ ? 3 : 7;
    e.sout = s_ ? mc[3] : md[7];
    e.cout = (mn >= last);
    e.crc  = mc;
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      g = sb_q.pop_front();
      chk("sout", {31'b0, sout}, {31'b0, g.sout});
      chk("cout", {31'b0, cout}, {31'b0, g.cout});
      chk("crc",  {28'b0, crc},  {28'b0, g.crc});
    end
    if (!c_ && !l_ && e_) stream = {stream[30:0], sout};
    @(posedge clk);
    if (c_) begin
      md = 0; mc = 0; mn = 0;
    end else if (l_) begin
      md = d_; mc = 0; mn = 0;
    end else if (e_) begin
      if (!s_) begin
        logic fb;
        fb = md[7] ^ mc[3];
        md = md << 1;
        mc = (mc << 1) ^ (fb ? 4'b0011 : 4'b0000);
      end else begin
        mc = mc << 1;
      end
      mn = (mn >= last) ? 0 : mn + 1;
    end
    #1;
  endtask

  // Loads a word and shifts out the whole frame. The frame is then checked
  // against the data word followed by its CRC.
  task automatic frame(input logic [7:0] v);
    stream = 0;
    cyc(0, 1, 0, 0, v);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 8'h00);
    chk("frame_crc", {28'b0, crc}, {28'b0, crc_div(v)});
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 8'h00);
    chk("frame_stream", {20'b0, stream[11:0]}, {20'b0, v, crc_div(v)});
  endtask

  initial begin
    clr = 1; load = 1; sel = 0; en = 1; din = 8'hFF;
    md = 0; mc = 0; mn = 0; stream = 0;
    // Two reset edges while Load and ShiftEn toggle. Load must be ignored.
    @(posedge clk); #1;
    load = 0; en = 0;
    @(posedge clk); #1;
    cyc(0, 0, 0, 0, 8'h00);
    chk("rst_sout", {31'b0, sout}, 0);
    chk("rst_cout", {31'b0, cout}, 0);
    chk("rst_crc",  {28'b0, crc},  0);

    // 0xA5 data phase followed by the CRC phase
    stream = 0;
    cyc(0, 1, 0, 0, 8'hA5);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 8'h00);
    chk("a5_data", {24'b0, stream[7:0]}, 32'hA5);
    chk("a5_crc", {28'b0, crc}, 32'hB);
    chk("a5_cout_wrap", {31'b0, cout}, 0);
    stream = 0;
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 8'h00);
    chk("a5_crcbits", {28'b0, stream[3:0]}, 32'hB);
    chk("a5_crc_end", {28'b0, crc}, 0);

    // An all-zero frame
    frame(8'h00);
    chk("zero_stream", {20'b0, stream[11:0]}, 0);

    // 0xA5 with a three-cycle ShiftEn gap after bit 4
    stream = 0;
    cyc(0, 1, 0, 0, 8'hA5);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 8'h00);
    chk("gap_data", {24'b0, stream[7:0]}, 32'hA5);
    chk("gap_crc", {28'b0, crc}, 32'hB);

    // Load asserted with ShiftEn at N=5. The load wins.
    cyc(0, 1, 0, 0, 8'hA5);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 8'h00);
    cyc(0, 1, 0, 1, 8'h3C);
    chk("ldwin_sout", {31'b0, sout}, 0);
    chk("ldwin_crc", {28'b0, crc}, 0);
    chk("ldwin_cout", {31'b0, cout}, 0);
    frame(8'h3C);

    // Select raised at N=6. Cout must rise at once, and the next shift wraps N.
    cyc(0, 1, 0, 0, 8'hFF);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 8'h00);
    sel = 1; #1;
    chk("midsel_cout", {31'b0, cout}, 1);
    cyc(0, 0, 1, 1, 8'h00);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 8'h00);

    // CLR in the middle of a frame, together with ShiftEn
    cyc(0, 1, 0, 0, 8'hC3);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 8'h00);
    cyc(1, 0, 0, 1, 8'h00);
    chk("midclr_sout", {31'b0, sout}, 0);
    chk("midclr_crc", {28'b0, crc}, 0);
    chk("midclr_cout", {31'b0, cout}, 0);
    cyc(0, 0, 0, 1, 8'h00);

    // Random frames
    for (int k = 0; k < 6; k++) frame(8'($urandom_range(0, 255)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mb_crc_serializer.md
Name: mb_crc_serializer

Overview:
- Serial-link transmit datapath, directly downstream of the link controller.
- Takes the controller's Load and Select strobes plus a shift enable. Parallel-loads a data word, shifts it out MSB first, then appends a serially computed CRC.
- Drives Cout, the bit-counter terminal flag, back to the controller so it can sequence the data and CRC phases.
- Uses no gated clock. All shifting is qualified by ShiftEn on CLK.

Parameters:
DATA_W, 8, data word width in bits (>=2)
CRC_W, 4, CRC width in bits (>=2, <=DATA_W)
POLY, 4'b0011, generator polynomial low CRC_W bits; implicit x^CRC_W term (default x^4+x+1)
CRC_INIT, 4'b0000, CRC register value after Load

Ports:
CLK  input  1  clock, all state updates on rising edge
CLR  input  1  reset, synchronous, active-high
Load  input  1  active-high parallel-load strobe
Select  input  1  phase select: 0 = data phase, 1 = CRC phase
ShiftEn  input  1  active-high shift qualifier, one bit per enabled cycle
Din  input  DATA_W  parallel data word, sampled on Load
Sout  output  1  serial output bit
Cout  output  1  terminal-count flag for the current phase
CRC  output  CRC_W  current CRC register contents, for observation and debug

Behaviour:
- State:
  - data register D[DATA_W-1:0]
  - CRC register C[CRC_W-1:0]
  - bit counter N, width clog2(DATA_W); it must hold DATA_W-1.
- Reset: CLR=1 at a rising edge sets D=0, C=CRC_INIT, N=0.
  - Resulting outputs: Sout=0, CRC=CRC_INIT, Cout=0.
- Priority per edge: CLR > Load > ShiftEn > hold.
- Load=1:
  - D<=Din, C<=CRC_INIT, N<=0.
  - Any ShiftEn in the same cycle is ignored.
- ShiftEn=1, Select=0 (data phase):
  - fb = D[DATA_W-1] ^ C[CRC_W-1]
  - D <= D<<1, zero fill
  - C <= (C<<1) ^ (fb ? POLY : 0)
- ShiftEn=1, Select=1 (CRC phase):
  - C <= C<<1, zero fill
  - D holds
- Counter, on each enabled shift:
  - N <= (N >= LAST) ? 0 : N+1
  - LAST = DATA_W-1 when Select=0, CRC_W-1 when Select=1.
  - N wraps to 0 on the terminal shift, so the CRC phase starts at N=0 with no extra clear.
- Sout = Select ? C[CRC_W-1] : D[DATA_W-1].
  - Combinational from registers and Select.
  - The bit on Sout during an enabled cycle is the bit being shifted out by that edge.
- Cout = (N >= LAST) for the current Select.
  - Combinational, not qualified by ShiftEn.
  - High for the whole cycle in which the last bit of the phase is presented.
  - The controller samples it on the same edge that performs the final shift.
- Select changing mid-phase:
  - N is not cleared; LAST switches immediately.
  - If N >= new LAST, Cout asserts and the next enabled shift wraps N to 0.
- ShiftEn=0: all registers hold, outputs stable.
- Reset mid-frame: CLR at any point abandons the frame; the next frame needs a fresh Load.
- Frame length: DATA_W + CRC_W enabled shifts after Load. The stream is the data MSB first, then the remainder of Din*x^CRC_W mod G, MSB first.

Test Plan:
- CLR high 2 cycles, with Load and ShiftEn toggling -> D=0, C=0, N=0, Sout=0, Cout=0. Load is ignored while CLR is high.
- Load Din=0xA5, Select=0, then 8 ShiftEn cycles:
  - Sout sequence 1,0,1,0,0,1,0,1.
  - Cout high only in the 8th cycle (N=7).
  - CRC=0xB after the 8th edge and N=0.
- Continue with Select=1 for 4 ShiftEn cycles -> Sout 1,0,1,1. Cout high only in the 4th cycle. CRC=0x0 afterwards.
- Load Din=0x00, full 12-bit frame -> Sout all 0. CRC stays 0x0. Cout pulses at data bit 8 and CRC bit 4.
- During the 0xA5 data phase, deassert ShiftEn for 3 cycles after bit 4 -> Sout, N and CRC hold. Resuming gives an identical stream and final CRC=0xB.
- Assert Load with Din=0x3C together with ShiftEn mid-frame (N=5) -> load wins: D=0x3C, C=0, N=0, Sout=0. Then assert CLR mid-frame -> all state returns to reset values on that edge.
